// File: rtl/ram_dp_clr.sv
// Dual-port data RAM: write/async-read port A, registered read port B.
// Define RAM_CLEAR_EN to build the sequential zero-fill engine.
module ram_dp_clr #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  clear_i,
  output logic                  busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

`ifdef RAM_CLEAR_EN

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q;
  logic [ADDR_WIDTH-1:0] clr_ptr_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Sweep ends on the all-ones address, never by wrap-around.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        if (clr_ptr_q == PTR_LAST) begin
          state_d = IDLE;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_ptr_d = '0;
      end
    endcase
  end

  assign busy = (state_q == CLEAR);

  // The sweep owns the write port; CPU writes are dropped meanwhile.
  always_comb begin
    wr_en   = !reset_i && (busy || load_i);
    wr_addr = busy ? clr_ptr_q : addr_i;
    wr_data = busy ? '0 : data_i;
  end

`else

  logic unused_clear;

  assign unused_clear = clear_i;
  assign busy         = 1'b0;

  always_comb begin
    wr_en   = !reset_i && load_i;
    wr_addr = addr_i;
    wr_data = data_i;
  end

`endif

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-first against a same-edge port A write.
  always_ff @(posedge clk_i) begin
    if (reset_i || busy) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

  assign data_o = (reset_i || busy) ? '0 : mem[addr_i];
  assign busy_o = busy;

endmodule
